// File: rtl/y86_store_buffer.sv
// y86_store_buffer
// Posted-write store buffer that sits between the y86 core memory bus and the
// backing data memory. Stores are queued in a circular FIFO and drained over a
// req/ack write port. Reads are answered combinationally, either from the
// youngest buffered store to the same address or from memory.
module y86_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AW-1:0]           cpu_A,
  input  logic [DW-1:0]           cpu_out,
  input  logic                    cpu_WE,
  input  logic                    cpu_RE,
  output logic [DW-1:0]           cpu_in,
  output logic [AW-1:0]           mem_raddr,
  input  logic [DW-1:0]           mem_rdata,
  output logic [AW-1:0]           mem_waddr,
  output logic [DW-1:0]           mem_wdata,
  output logic                    mem_wreq,
  input  logic                    mem_wack,
  output logic [$clog2(DEPTH):0]  sb_count,
  output logic                    sb_empty,
  output logic                    sb_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  // Entry storage and FIFO bookkeeping
  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          full_s;
  logic          empty_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic          hit_s;
  logic [DW-1:0] fwd_data_s;
  logic [PW-1:0] idx_s;

  // Decode occupancy and decide push/pop/drop for this cycle
  always_comb begin
    full_s  = (count_q == CNT_MAX);
    empty_s = (count_q == '0);
    // A pop frees a slot in the same edge, so a full buffer can still accept.
    pop_s   = !empty_s && mem_wack;
    push_s  = cpu_WE && (!full_s || pop_s);
    drop_s  = cpu_WE && full_s && !pop_s;
  end

  // Next-state for pointers, count, sticky overflow and entry contents
  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push_s) begin
      addr_d[tail_q] = cpu_A;
      data_d[tail_q] = cpu_out;
      tail_d         = tail_q + PTR_ONE;
    end else begin
      tail_d = tail_q;
    end

    if (pop_s) begin
      head_d = head_q + PTR_ONE;
    end else begin
      head_d = head_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (drop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Search valid entries oldest to youngest so the youngest match wins
  always_comb begin
    hit_s      = 1'b0;
    fwd_data_s = '0;
    idx_s      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx_s] == cpu_A)) begin
        hit_s      = 1'b1;
        fwd_data_s = data_q[idx_s];
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Read path: forwarded store data, else memory; zero when not reading
  always_comb begin
    if (!cpu_RE) begin
      cpu_in = '0;
    end else if (hit_s) begin
      cpu_in = fwd_data_s;
    end else begin
      cpu_in = mem_rdata;
    end
  end

  // State registers; reset clears occupancy so mem_wreq drops immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      data_q     <= data_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs come straight from state, except the combinational read path
  assign mem_raddr   = cpu_A;
  assign mem_waddr   = addr_q[head_q];
  assign mem_wdata   = data_q[head_q];
  assign mem_wreq    = !empty_s;
  assign sb_count    = count_q;
  assign sb_empty    = empty_s;
  assign sb_overflow = overflow_q;

endmodule

// File: tb/tb_y86_store_buffer.sv
// Testbench for y86_store_buffer: directed stimulus, expected memory writes and
// read results queued by the driver and consumed by an independent monitor.
module tb_y86_store_buffer;

  logic        clk;
  logic        rst_n;
  logic [31:0] cpu_A;
  logic [31:0] cpu_out;
  logic        cpu_WE;
  logic        cpu_RE;
  logic [31:0] cpu_in;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_wreq;
  logic        mem_wack;
  logic [2:0]  sb_count;
  logic        sb_empty;
  logic        sb_overflow;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_w [$];
  logic [31:0] exp_r [$];
  logic [63:0] ew;
  logic [31:0] er;

  y86_store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_A      (cpu_A),
    .cpu_out    (cpu_out),
    .cpu_WE     (cpu_WE),
    .cpu_RE     (cpu_RE),
    .cpu_in     (cpu_in),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wreq   (mem_wreq),
    .mem_wack   (mem_wack),
    .sb_count   (sb_count),
    .sb_empty   (sb_empty),
    .sb_overflow(sb_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, expv);
    end
  endtask

  // Monitor: consume expected writes on accepted handshakes and expected reads
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wreq && mem_wack) begin
        if (exp_w.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got=%0h want=none", mem_waddr);
        end else begin
          ew = exp_w.pop_front();
          chk("wr_addr", mem_waddr, ew[63:32]);
          chk("wr_data", mem_wdata, ew[31:0]);
        end
      end
      if (cpu_RE) begin
        if (exp_r.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_read: got=%0h want=none", cpu_in);
        end else begin
          er = exp_r.pop_front();
          chk("rd_data", cpu_in, er);
        end
      end
    end
  end

  task automatic drive(input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] d, input logic ack, input logic [31:0] rd);
    cpu_WE    = we;
    cpu_RE    = re;
    cpu_A     = a;
    cpu_out   = d;
    mem_wack  = ack;
    mem_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic ack,
                       input logic accept);
    drive(1'b1, 1'b0, a, d, ack, 32'h0);
    if (accept) exp_w.push_back({a, d});
    tick();
    idle();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] mrd, input logic ack,
                    input logic [31:0] expv);
    drive(1'b0, 1'b1, a, 32'h0, ack, mrd);
    exp_r.push_back(expv);
    tick();
    idle();
  endtask

  task automatic drain();
    int n;
    n = 0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    while (!sb_empty && n < 40) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(sb_empty), 32'd1);
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    exp_w.delete();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    #3;
    chk("rst_count", 32'(sb_count), 32'd0);
    chk("rst_empty", 32'(sb_empty), 32'd1);
    chk("rst_wreq", 32'(mem_wreq), 32'd0);
    chk("rst_ovf", 32'(sb_overflow), 32'd0);
    #9;
    rst_n = 1'b1;
    tick();

    // Single store, held without ack, then acked
    store(32'h100, 32'hDEADBEEF, 1'b0, 1'b1);
    chk("st_wreq", 32'(mem_wreq), 32'd1);
    chk("st_waddr", mem_waddr, 32'h100);
    chk("st_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_count", 32'(sb_count), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_wreq", 32'(mem_wreq), 32'd1);
      chk("hold_waddr", mem_waddr, 32'h100);
      chk("hold_wdata", mem_wdata, 32'hDEADBEEF);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    tick();
    idle();
    chk("ack_empty", 32'(sb_empty), 32'd1);
    chk("ack_wreq", 32'(mem_wreq), 32'd0);

    // Youngest-match forwarding, memory fallback, read with same-cycle store
    store(32'h40, 32'h1, 1'b0, 1'b1);
    store(32'h40, 32'h2, 1'b0, 1'b1);
    rd(32'h40, 32'h99, 1'b0, 32'h2);
    rd(32'h44, 32'h55, 1'b0, 32'h55);
    drive(1'b1, 1'b1, 32'h44, 32'h66, 1'b0, 32'h55);
    exp_w.push_back({32'h44, 32'h66});
    exp_r.push_back(32'h55);
    tick();
    idle();
    rd(32'h44, 32'h55, 1'b0, 32'h66);
    drive(1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h77);
    #1;
    chk("no_re_zero", cpu_in, 32'h0);
    chk("raddr", mem_raddr, 32'h40);
    drain();

    // Overflow: fifth store dropped, drain order preserved, flag sticky
    for (int i = 0; i < 4; i++) begin
      store(32'h200 + 32'(i * 4), 32'hA0 + 32'(i), 1'b0, 1'b1);
    end
    store(32'h300, 32'hBAD, 1'b0, 1'b0);
    chk("ovf_flag", 32'(sb_overflow), 32'd1);
    chk("ovf_count", 32'(sb_count), 32'd4);
    drain();
    chk("ovf_sticky", 32'(sb_overflow), 32'd1);

    // Full buffer with simultaneous pop accepts the new store
    do_reset();
    chk("rst2_ovf", 32'(sb_overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      store(32'h500 + 32'(i * 4), 32'hB0 + 32'(i), 1'b0, 1'b1);
    end
    store(32'h600, 32'hC0, 1'b1, 1'b1);
    chk("full_pp_count", 32'(sb_count), 32'd4);
    chk("full_pp_ovf", 32'(sb_overflow), 32'd0);
    drain();

    // Read of head entry while it is being acked still forwards
    store(32'h700, 32'h77, 1'b0, 1'b1);
    rd(32'h700, 32'h99, 1'b1, 32'h77);
    rd(32'h700, 32'h99, 1'b0, 32'h99);
    chk("head_ack_empty", 32'(sb_empty), 32'd1);

    // Asynchronous reset mid-cycle discards pending entries
    store(32'h800, 32'h8, 1'b0, 1'b1);
    store(32'h804, 32'h9, 1'b0, 1'b1);
    chk("pre_rst_count", 32'(sb_count), 32'd2);
    #1;
    rst_n = 1'b0;
    exp_w.delete();
    #1;
    chk("async_wreq", 32'(mem_wreq), 32'd0);
    chk("async_count", 32'(sb_count), 32'd0);
    chk("async_empty", 32'(sb_empty), 32'd1);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_wreq", 32'(mem_wreq), 32'd0);
      chk("post_rst_count", 32'(sb_count), 32'd0);
    end
    idle();
    tick();

    chk("exp_w_left", 32'(exp_w.size()), 32'd0);
    chk("exp_r_left", 32'(exp_r.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/y86_store_buffer.md
Name: y86_store_buffer

Overview:
- Posted-write store buffer between the y86 sequential core's memory bus and the backing data memory.
- Core stores (bus_WE) are accepted in one cycle into a DEPTH-entry FIFO; entries drain to memory over a req/ack write port.
- Core reads (bus_RE) are answered combinationally in the same cycle: youngest matching buffered store if one exists, else the memory's asynchronous read data.
- Decouples core from slow memory writes while preserving read-after-write ordering.

Parameters:
DEPTH, 4, number of buffered stores (power of two, >=2)
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cpu_A  in  AW  core bus address
cpu_out  in  DW  core store data
cpu_WE  in  1  core store strobe
cpu_RE  in  1  core read strobe
cpu_in  out  DW  read data to core, combinational
mem_raddr  out  AW  memory read address (= cpu_A)
mem_rdata  in  DW  memory async read data
mem_waddr  out  AW  head entry address
mem_wdata  out  DW  head entry data
mem_wreq  out  1  head entry valid, write request
mem_wack  in  1  memory accepts write this cycle
sb_count  out  log2(DEPTH)+1  occupied entries
sb_empty  out  1  count==0 (core may halt only when set)
sb_overflow  out  1  sticky: store dropped while full

Behaviour:
- Reset (async, rst_n=0): count=0, head/tail pointers=0, sb_overflow=0, mem_wreq=0 immediately, sb_empty=1; entry contents don't-care. Reset mid-drain discards all entries; no further mem_wreq until new store.
- FIFO: circular, head/tail wrap modulo DEPTH. Push when cpu_WE at edge: entry {cpu_A, cpu_out} written at tail, tail++.
- Drain: mem_wreq = !sb_empty; mem_waddr/mem_wdata = head entry, stable while mem_wreq high and no ack. Pop at edge where mem_wreq && mem_wack; head++. mem_wack while empty ignored.
- Simultaneous push and pop: both take effect, count unchanged. Allowed when full (pop frees slot). When empty, pushed entry appears at head next cycle (no same-cycle bypass to memory).
- Full (count==DEPTH) with cpu_WE and no pop: store dropped, state unchanged, sb_overflow set and held until reset.
- Read: mem_raddr = cpu_A always. When cpu_RE: compare cpu_A against all valid entries (full AW-bit equality); if any match, cpu_in = data of youngest matching entry (closest to tail); else cpu_in = mem_rdata. Head entry being acked this cycle is still valid for matching. When !cpu_RE: cpu_in = 0.
- Forwarding is exact-address only; partially overlapping unaligned stores are not merged (core issues aligned word accesses only).
- cpu_RE and cpu_WE same cycle: read result uses pre-push contents; push proceeds.
- Latency: store accepted 0 cycles (registered at edge); earliest mem_wreq for it one cycle after push; read 0 cycles (combinational).
- sb_count increments on push-only, decrements on pop-only, saturates never (overflow path prevents >DEPTH).

Test Plan:
- Reset then store A=0x100 D=0xDEADBEEF, mem_wack=0 -> next cycle mem_wreq=1, mem_waddr=0x100, mem_wdata=0xDEADBEEF, sb_count=1; hold 3 cycles stable; mem_wack=1 one cycle -> sb_empty=1, mem_wreq=0.
- Stores 0x40<-1 then 0x40<-2, wack=0; read cpu_A=0x40 -> cpu_in=2; read 0x44 with mem_rdata=0x55 -> cpu_in=0x55.
- Fill 4 stores, wack=0, 5th store -> dropped, sb_overflow=1, sb_count=4; drain all four in order, addresses match push order; sb_overflow stays 1.
- Full buffer, 5th store with mem_wack=1 same cycle -> accepted, sb_count=4, sb_overflow=0, new entry drains last.
- Read address matching head while mem_wack=1 same cycle -> cpu_in = head data; next cycle same read -> mem_rdata.
- 2 entries pending, assert rst_n=0 mid-cycle -> mem_wreq falls without clock edge, sb_count=0; after release no mem_wreq.
